// File: rtl/conv_encoder_pkg.sv
// rtl/conv_encoder_pkg.sv - generator taps, rate encodings and puncture constants shared by the encoder
package conv_encoder_pkg;

  localparam logic [6:0] G0_DEFAULT = 7'o133;
  localparam logic [6:0] G1_DEFAULT = 7'o171;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'b00,
    RATE_2_3 = 2'b01,
    RATE_3_4 = 2'b10,
    RATE_RSVD = 2'b11
  } rate_e;

  localparam logic [1:0] PERIOD_2_3 = 2'd2;
  localparam logic [1:0] PERIOD_3_4 = 2'd3;

  // keep[0] = generator A bit, keep[1] = generator B bit
  localparam logic [1:0] KEEP_AB = 2'b11;
  localparam logic [1:0] KEEP_A  = 2'b01;
  localparam logic [1:0] KEEP_B  = 2'b10;

  function automatic logic parity7(input logic [6:0] vec, input logic [6:0] taps);
    return ^(vec & taps);
  endfunction

endpackage

// File: rtl/convolutional_encoder_puncture_mask.sv
// rtl/convolutional_encoder_puncture_mask.sv - per-phase keep mask and phase step; built only with CONV_ENCODER_PUNCTURE_EN
`ifdef CONV_ENCODER_PUNCTURE_EN
module puncture_mask
  import conv_encoder_pkg::*;
(
  input  rate_e       i_rate,
  input  logic [1:0]  i_phase,
  output logic [1:0]  o_keep,
  output logic [1:0]  o_next_phase
);

  always_comb begin
    o_keep       = KEEP_AB;
    o_next_phase = 2'd0;
    case (i_rate)
      RATE_2_3: begin
        if (i_phase == 2'd1) o_keep = KEEP_A;
        o_next_phase = (i_phase == PERIOD_2_3 - 2'd1) ? 2'd0 : i_phase + 2'd1;
      end
      RATE_3_4: begin
        if (i_phase == 2'd1)      o_keep = KEEP_A;
        else if (i_phase == 2'd2) o_keep = KEEP_B;
        o_next_phase = (i_phase == PERIOD_3_4 - 2'd1) ? 2'd0 : i_phase + 2'd1;
      end
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/convolutional_encoder.sv
// rtl/convolutional_encoder.sv - K=7 rate-1/2 encoder, 2-bit output buffer; CONV_ENCODER_PUNCTURE_EN adds rates 2/3 and 3/4
module convolutional_encoder
  import conv_encoder_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [1:0]  i_rate,
  input  logic        i_input,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_output,
  output logic        o_out_valid,
  input  logic        i_out_ready
);

  logic [5:0] r_sr;
  logic [1:0] r_buf;
  logic [1:0] r_cnt;

  logic [6:0] w_vec;
  logic       w_a;
  logic       w_b;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_keep;
  logic [1:0] w_load_buf;
  logic [1:0] w_load_cnt;

  assign w_vec = {i_input, r_sr};
  assign w_a   = parity7(w_vec, G0);
  assign w_b   = parity7(w_vec, G1);

  // A push is only allowed once the buffer is empty or is emptying this cycle
  assign o_in_ready  = !i_reset && !i_start &&
                       (r_cnt == 2'd0 || (r_cnt == 2'd1 && i_out_ready));
  assign o_out_valid = (r_cnt != 2'd0);
  assign o_output    = r_buf[0];
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = o_out_valid && i_out_ready;

`ifdef CONV_ENCODER_PUNCTURE_EN
  rate_e      r_rate;
  logic [1:0] r_phase;
  logic [1:0] w_next_phase;

  puncture_mask u_puncture_mask (
    .i_rate       (r_rate),
    .i_phase      (r_phase),
    .o_keep       (w_keep),
    .o_next_phase (w_next_phase)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rate  <= RATE_1_2;
      r_phase <= 2'd0;
    end else if (i_start) begin
      r_rate  <= rate_e'(i_rate);
      r_phase <= 2'd0;
    end else if (w_push) begin
      r_phase <= w_next_phase;
    end
  end
`else
  logic w_unused_rate;
  assign w_unused_rate = ^i_rate;
  assign w_keep        = KEEP_AB;
`endif

  always_comb begin
    w_load_buf = 2'b00;
    w_load_cnt = 2'd0;
    case (w_keep)
      KEEP_AB: begin
        w_load_buf = {w_b, w_a};
        w_load_cnt = 2'd2;
      end
      KEEP_A: begin
        w_load_buf = {1'b0, w_a};
        w_load_cnt = 2'd1;
      end
      KEEP_B: begin
        w_load_buf = {1'b0, w_b};
        w_load_cnt = 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_start) begin
      r_sr  <= 6'd0;
      r_buf <= 2'b00;
      r_cnt <= 2'd0;
    end else if (w_push) begin
      // Push implies the buffer is empty after any same-cycle pop
      r_sr  <= {i_input, r_sr[5:1]};
      r_buf <= w_load_buf;
      r_cnt <= w_load_cnt;
    end else if (w_pop) begin
      r_buf <= {1'b0, r_buf[1]};
      r_cnt <= r_cnt - 2'd1;
    end
  end

endmodule
